// File: rtl/bank_readout_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// bank_readout_scheduler_pkg : job record, state encoding and constants
// Revision : 1.0
// ============================================================================
package bank_readout_scheduler_pkg;

  localparam int SAMPLES_PER_BANK = 200;
  localparam int ADDR_W           = 9;
  localparam int LEN_W            = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_PRESENT = 2'd3;

  typedef struct packed {
    logic             bank;
    logic [LEN_W-1:0] len;
  } job_t;

  // Partial-burst length: last written index plus one, never beyond a full bank.
  function automatic logic [LEN_W-1:0] burst_len(input logic [7:0] idx_final, input int spb);
    logic [8:0] n;
    n = {1'b0, idx_final} + 9'd1;
    if (n > 9'(spb)) n = 9'(spb);
    return n[LEN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_readout_scheduler_job_queue.sv
`default_nettype none
// ============================================================================
// bank_readout_scheduler_job_queue : 2-entry job FIFO with per-bank outstanding flags
// Revision : 1.0
// ============================================================================
module bank_readout_scheduler_job_queue
  import bank_readout_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  job_t       i_push_job,
  input  logic       i_pop,
  input  logic [1:0] i_release,
  output job_t       o_head,
  output logic [1:0] o_count,
  output logic [1:0] o_pending
);

  job_t       r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic [1:0] r_pending;

  logic       w_pop;
  logic       w_push;
  logic [1:0] w_set;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);
  assign w_set  = w_push ? (i_push_job.bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_pending <= 2'b00;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_job;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count   <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      // A bank stays outstanding from enqueue until its job has fully streamed.
      r_pending <= (r_pending & ~i_release) | w_set;
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/bank_readout_scheduler.sv
`default_nettype none
// ============================================================================
// bank_readout_scheduler : streams ping-pong bank jobs to downstream, releases banks
// Revision : 1.0
// ============================================================================
module bank_readout_scheduler #(
  parameter int SAMPLES_PER_BANK = 200,
  parameter int DATA_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bank0_full,
  input  logic              bank1_full,
  input  logic              memorization_completed,
  input  logic              wr_bank,
  input  logic [7:0]        idx_final,
  output logic [8:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_bank,
  output logic [1:0]        bank_released,
  output logic              busy,
  output logic              overrun
);
  import bank_readout_scheduler_pkg::*;

  localparam logic [LEN_W-1:0] C_FULL_LEN = LEN_W'(SAMPLES_PER_BANK);

  state_t            r_state;
  logic              r_bank;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_bank_released;
  logic              r_overrun;

  logic              w_evt_valid;
  job_t              w_evt_job;
  logic              w_evt_conflict;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_handshake;
  logic [1:0]        w_release;
  logic [1:0]        w_pending;
  logic [1:0]        w_count;
  job_t              w_head;

  // Full events win over a simultaneous burst end; bank 0 wins if both banks fill at once.
  always_comb begin
    w_evt_valid = 1'b0;
    w_evt_job   = '0;
    if (bank0_full) begin
      w_evt_valid   = 1'b1;
      w_evt_job.len = C_FULL_LEN;
    end else if (bank1_full) begin
      w_evt_valid    = 1'b1;
      w_evt_job.bank = 1'b1;
      w_evt_job.len  = C_FULL_LEN;
    end else if (memorization_completed) begin
      w_evt_valid    = 1'b1;
      w_evt_job.bank = wr_bank;
      w_evt_job.len  = burst_len(idx_final, SAMPLES_PER_BANK);
    end
  end

  assign w_evt_conflict = (bank0_full & bank1_full)
                        | ((bank0_full | bank1_full) & memorization_completed);
  assign w_drop      = w_evt_valid & w_pending[w_evt_job.bank];
  assign w_push      = w_evt_valid & ~w_drop;
  assign w_pop       = (r_state == ST_IDLE) & (w_count != 2'd0);
  assign w_last      = (r_idx == (r_len - LEN_W'(1)));
  assign w_handshake = (r_state == ST_PRESENT) & out_ready;
  assign w_release   = (w_handshake & w_last) ? (r_bank ? 2'b10 : 2'b01) : 2'b00;

  bank_readout_scheduler_job_queue u_job_queue (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_job (w_evt_job),
    .i_pop      (w_pop),
    .i_release  (w_release),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_pending  (w_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_bank          <= 1'b0;
      r_len           <= '0;
      r_idx           <= '0;
      r_out_data      <= '0;
      r_bank_released <= 2'b00;
      r_overrun       <= 1'b0;
    end else begin
      r_bank_released <= w_release;
      r_overrun       <= r_overrun | w_drop | w_evt_conflict;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_bank  <= w_head.bank;
            r_len   <= w_head.len;
            r_idx   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE:   r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_out_data <= rd_data;
          r_state    <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_ready) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + LEN_W'(1);
              r_state <= ST_ISSUE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_addr       = {r_bank, r_idx};
  assign out_data      = r_out_data;
  assign out_valid     = (r_state == ST_PRESENT);
  assign out_last      = out_valid & w_last;
  assign out_bank      = r_bank;
  assign bank_released = r_bank_released;
  assign busy          = (r_state != ST_IDLE) | (w_count != 2'd0);
  assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: doc/bank_readout_scheduler.md
# bank_readout_scheduler

Sequences readout of the two-bank (ping-pong) sample memory filled by the capture-side memory controller. Bank-full and end-of-burst events from the writer become read jobs, queued in arrival order. Each job's samples stream to the downstream spectrogram/FFT stage over a valid/ready interface. Each bank is released back to the writer once it has been fully streamed.

## Interface
Parameters:
- SAMPLES_PER_BANK, 200: samples in a full bank; full-bank job length.
- DATA_W, 8: sample width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- bank0_full  in  1  1-cycle pulse: bank 0 holds SAMPLES_PER_BANK samples.
- bank1_full  in  1  1-cycle pulse: bank 1 holds SAMPLES_PER_BANK samples.
- memorization_completed  in  1  1-cycle pulse: burst ended; bank `wr_bank` is partially filled.
- wr_bank  in  1  bank currently written by the writer, sampled with memorization_completed.
- idx_final  in  8  last written index of a partial burst.
- rd_addr  out  9  {job bank, index}; combinational from registered job bank and read index.
- rd_data  in  DATA_W  synchronous-read RAM output; valid the cycle after rd_addr is presented.
- out_data  out  DATA_W  sample to downstream.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  final sample of the current job; qualified by out_valid.
- out_bank  out  1  bank of the current job.
- bank_released  out  2  1-cycle pulse, bit b = bank b fully streamed.
- busy  out  1  job active or queued.
- overrun  out  1  sticky; a job was dropped.

## Operation
- Job = {bank, len}, len in 1..SAMPLES_PER_BANK.
- bankN_full enqueues {N, SAMPLES_PER_BANK}.
- memorization_completed enqueues {wr_bank, min(idx_final+1, SAMPLES_PER_BANK)}.
- Queue: 2-entry FIFO, oldest job served first. At most one outstanding job per bank, counting queued and active jobs.
- An event for a bank that already has an outstanding job is dropped and sets overrun. The existing job is kept.
- Same-cycle full pulse and memorization_completed: the full event is taken, the other is dropped, and overrun is set.
- FSM:
  - IDLE: if the queue is non-empty, pop the oldest job, load job bank/len, clear the read index, go to ISSUE.
  - ISSUE: rd_addr = {bank, idx}; the RAM latches it at the clock edge; go to CAPTURE.
  - CAPTURE: out_data <= rd_data; go to PRESENT.
  - PRESENT: out_valid=1; out_last=1 when idx==len-1. On out_ready:
    - if idx==len-1, pulse bank_released[bank] and go to IDLE;
    - else idx+1 and go to ISSUE.
- Holding rules:
  - out_data, out_bank and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- Enqueue during the same cycle as a pop is legal; the FIFO count is net of both.
- busy = (state != IDLE) | queue non-empty.
- Reset values, including mid-job reset:
  - out_valid=0, out_last=0, out_bank=0, out_data=0, rd_addr=0, bank_released=0, overrun=0, busy=0;
  - queue emptied, state IDLE.
  - No release pulse is generated for an aborted job.

## Timing
- Event pulse at edge T: the job is visible in the queue after T. If IDLE with an empty queue, ISSUE starts at T+1, out_valid rises at T+3.
- Per sample: 3 cycles minimum (ISSUE, CAPTURE, PRESENT), plus any out_ready stall cycles.
- Full 200-sample job with out_ready held high: 600 cycles from the first ISSUE to the bank_released pulse.
  - bank_released asserts the cycle after the last handshake, for one cycle.
  - The next job's ISSUE begins no earlier than 1 cycle after that.
- The writer refills a bank every ≥200 sample periods; the readout clock must exceed 3× the sample rate to avoid overrun.

## Structure
- Shared package:
  - state enum (IDLE, ISSUE, CAPTURE, PRESENT);
  - job struct {bank: 1 bit, len: 8 bits};
  - constant SAMPLES_PER_BANK=200;
  - ADDR_W=9.
- Sub-module `job_queue`: 2-entry job FIFO with push/pop/count and per-bank outstanding flags.
- The FSM, read index counter and output register live in the top level.

## Test plan
- Single full job: bank0_full pulse with rd_data=addr[7:0] model, out_ready=1.
  - Expect 200 beats, data 0..199, out_bank=0, out_last only on data 199.
  - Expect bank_released=01 one cycle after the last handshake.
- Partial burst: memorization_completed with wr_bank=1, idx_final=49.
  - Expect 50 beats from addresses 256..305, out_last on the 50th, bank_released=10.
- Back-to-back: bank0_full then bank1_full 5 cycles later.
  - Expect the bank 0 job to complete entirely before the first bank 1 beat, and busy=1 throughout.
- Backpressure: out_ready random 30% duty on a full job.
  - Expect out_data stable while stalled, no lost or duplicate beats, 200 beats total.
- Overrun: bank0_full twice before job 0 ends; separately, same-cycle bank1_full and memorization_completed.
  - Expect overrun=1 sticky in both cases and only one job per bank streamed.
- Reset mid-job: assert reset at beat 73.
  - Expect out_valid=0 immediately, no bank_released pulse, busy=0.
  - A new bank1_full after release streams 200 beats normally.
